fpmult_round_pack: RTL and testbench

FPMULT_ROUND_PACK -- requirements
Module: fpmult_round_pack

---
 rtl/fpmult_pkg.sv | 34 +++
 rtl/fpmult_rne_select.sv | 39 +++
 rtl/fpmult_round_pack.sv | 187 ++++++++++++++++++
 tb/tb_fpmult_round_pack.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpmult_pkg
// Description : Shared field widths, exponent bias, flag-bit positions and
//               result-class encoding for the multiplier round/pack stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fpmult_pkg;

  localparam int EXPONENT = 5;
  localparam int MANTISSA = 10;
  localparam int DWIDTH   = 1 + EXPONENT + MANTISSA;
  localparam int BIAS     = 15;

  // Bit positions inside the Flags vector {inexact, overflow, underflow, invalid}
  localparam int NFLAGS         = 4;
  localparam int FLAG_INEXACT   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INVALID   = 0;

  typedef logic [NFLAGS-1:0] flags_t;

  // Special-case class decided in S1, consumed by the S2 packer
  typedef enum logic [2:0] {
    RES_NORMAL = 3'd0,
    RES_ZERO   = 3'd1,
    RES_OVF    = 3'd2,
    RES_UNF    = 3'd3,
    RES_NAN    = 3'd4
  } res_class_t;

endpackage
`default_nettype wire

// File: rtl/fpmult_rne_select.sv
`default_nettype none
// ============================================================================
// Module      : fpmult_rne_select
// Description : Round-to-nearest-even decision and mantissa/exponent select.
//               Chooses between the truncated and incremented candidates and
//               takes the carry exponent when the mantissa increment wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module fpmult_rne_select
  import fpmult_pkg::*;
(
  input  logic [EXPONENT-1:0] i_round_e,
  input  logic [EXPONENT-1:0] i_round_ep,
  input  logic [MANTISSA-1:0] i_round_m,
  input  logic [MANTISSA-1:0] i_round_mp,
  input  logic                i_g,
  input  logic                i_r,
  input  logic                i_s,
  output logic [EXPONENT-1:0] o_e,
  output logic [MANTISSA-1:0] o_m
);

  logic w_up;

  // Round up above the halfway point, or exactly at it when the LSB is odd
  always_comb begin
    w_up = i_g && (i_r || i_s || i_round_m[0]);
    o_e  = i_round_e;
    o_m  = i_round_m;
    if (w_up) begin
      o_m = i_round_mp;
      if (&i_round_m) begin
        o_e = i_round_ep;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpmult_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : fpmult_round_pack
// Description : Two-stage rounding and packing back end of the FP multiplier.
//               S1 registers the rounded fields and special-case class,
//               S2 registers the packed result and exception flags.
//               Valid/ready handshake on both sides, 1 result per cycle.
//               Optional macro FPMULT_ROUND_FLAGS_EN builds the flag logic;
//               without it Flags is constant zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fpmult_round_pack
  import fpmult_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXPONENT-1:0] RoundE,
  input  logic [EXPONENT-1:0] RoundEP,
  input  logic [MANTISSA-1:0] RoundM,
  input  logic [MANTISSA-1:0] RoundMP,
  input  logic                Sign,
  input  logic                G,
  input  logic                R,
  input  logic                S,
  input  logic                ExpOvf,
  input  logic                ExpUnf,
  input  logic                InNaN,
  input  logic                InZero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   Z,
  output flags_t              Flags
);

  localparam logic [EXPONENT-1:0] C_EXP_ONES  = {EXPONENT{1'b1}};
  localparam logic [EXPONENT-1:0] C_EXP_ZERO  = {EXPONENT{1'b0}};
  localparam logic [MANTISSA-1:0] C_MAN_ZERO  = {MANTISSA{1'b0}};
  localparam logic [MANTISSA-1:0] C_MAN_QNAN  = {1'b1, {(MANTISSA-1){1'b0}}};

  // Pipeline state
  logic                r_s1_valid;
  logic                r_s1_sign;
  logic [EXPONENT-1:0] r_s1_e;
  logic [MANTISSA-1:0] r_s1_m;
  res_class_t          r_s1_class;
  logic                r_s2_valid;
  logic [DWIDTH-1:0]   r_z;

  logic                w_s1_adv;
  logic                w_in_fire;
  logic [EXPONENT-1:0] w_sel_e;
  logic [MANTISSA-1:0] w_sel_m;
  res_class_t          w_class;
  logic [DWIDTH-1:0]   w_z;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_in_fire = in_valid && in_ready;
  assign out_valid = r_s2_valid;
  assign Z         = r_z;

  fpmult_rne_select u_rne_select (
    .i_round_e  (RoundE),
    .i_round_ep (RoundEP),
    .i_round_m  (RoundM),
    .i_round_mp (RoundMP),
    .i_g        (G),
    .i_r        (R),
    .i_s        (S),
    .o_e        (w_sel_e),
    .o_m        (w_sel_m)
  );

  // Classify the result; a rounded exponent reaching all ones is an overflow
  always_comb begin
    w_class = RES_NORMAL;
    if (InNaN) begin
      w_class = RES_NAN;
    end else if (InZero) begin
      w_class = RES_ZERO;
    end else if (ExpOvf || (w_sel_e == C_EXP_ONES)) begin
      w_class = RES_OVF;
    end else if (ExpUnf) begin
      w_class = RES_UNF;
    end
  end

  // S1: capture rounded fields on input transfer; valid follows in_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_e     <= C_EXP_ZERO;
      r_s1_m     <= C_MAN_ZERO;
      r_s1_class <= RES_NORMAL;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire) begin
        r_s1_sign  <= Sign;
        r_s1_e     <= w_sel_e;
        r_s1_m     <= w_sel_m;
        r_s1_class <= w_class;
      end
    end
  end

  // Pack the S1 fields into the final encoding
  always_comb begin
    w_z = {r_s1_sign, r_s1_e, r_s1_m};
    case (r_s1_class)
      RES_NAN:  w_z = {1'b0, C_EXP_ONES, C_MAN_QNAN};
      RES_ZERO: w_z = {r_s1_sign, C_EXP_ZERO, C_MAN_ZERO};
      RES_UNF:  w_z = {r_s1_sign, C_EXP_ZERO, C_MAN_ZERO};
      RES_OVF:  w_z = {r_s1_sign, C_EXP_ONES, C_MAN_ZERO};
      default:  w_z = {r_s1_sign, r_s1_e, r_s1_m};
    endcase
  end

  // S2: output register, frozen while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_z        <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_z <= w_z;
      end
    end
  end

`ifdef FPMULT_ROUND_FLAGS_EN
  logic   r_s1_inexact;
  flags_t r_flags;
  flags_t w_flags;

  // Inexact is known from the discarded bits before rounding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_inexact <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_inexact <= G || R || S;
    end
  end

  // NaN and exact zero never report inexact
  always_comb begin
    w_flags = '0;
    case (r_s1_class)
      RES_NAN: begin
        w_flags[FLAG_INVALID] = 1'b1;
      end
      RES_OVF: begin
        w_flags[FLAG_OVERFLOW] = 1'b1;
        w_flags[FLAG_INEXACT]  = r_s1_inexact;
      end
      RES_UNF: begin
        w_flags[FLAG_UNDERFLOW] = 1'b1;
        w_flags[FLAG_INEXACT]   = r_s1_inexact;
      end
      RES_NORMAL: begin
        w_flags[FLAG_INEXACT] = r_s1_inexact;
      end
      default: w_flags = '0;
    endcase
  end

  // Flags travel alongside Z in S2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= '0;
    end else if (w_s1_adv && r_s1_valid) begin
      r_flags <= w_flags;
    end
  end

  assign Flags = r_flags;
`else
  assign Flags = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpmult_round_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmult_round_pack
// Description : Self-checking bench for fpmult_round_pack (half precision).
//               Directed corner cases, stall/reset scenarios and a random
//               phase scored against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmult_round_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  RoundE = '0, RoundEP = '0;
  logic [9:0]  RoundM = '0, RoundMP = '0;
  logic        Sign = 1'b0, G = 1'b0, R = 1'b0, S = 1'b0;
  logic        ExpOvf = 1'b0, ExpUnf = 1'b0, InNaN = 1'b0, InZero = 1'b0;
  logic [15:0] Z;
  logic [3:0]  Flags;

  fpmult_round_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RoundE    (RoundE),
    .RoundEP   (RoundEP),
    .RoundM    (RoundM),
    .RoundMP   (RoundMP),
    .Sign      (Sign),
    .G         (G),
    .R         (R),
    .S         (S),
    .ExpOvf    (ExpOvf),
    .ExpUnf    (ExpUnf),
    .InNaN     (InNaN),
    .InZero    (InZero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .Flags     (Flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sign;
    logic [4:0] e, ep;
    logic [9:0] m, mp;
    logic       g, r, s, ovf, unf, nan, zero;
  } stim_t;

  typedef struct {
    logic [15:0] z;
    logic [3:0]  f;
    int          t;
  } exp_t;

  exp_t        q[$];
  stim_t       cur;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          hold_v = 1'b0;
  logic [15:0] hold_z = '0;
  logic [3:0]  hold_f = '0;
  bit          dir_v = 1'b0;
  logic [15:0] dir_z = '0;
  logic [3:0]  dir_f = '0;
  bit          acc_last = 1'b0;

  // Flags exist only in the flag-enabled build
  function automatic logic [3:0] fx(input logic [3:0] f);
`ifdef FPMULT_ROUND_FLAGS_EN
    return f;
`else
    return f & 4'b0000;
`endif
  endfunction

  // Reference: round the mantissa as an integer by the value of the dropped bits
  function automatic void model(input stim_t s, output logic [15:0] z, output logic [3:0] f);
    int m, e, rem;
    bit up, inexact;
    m = int'(s.m);
    e = int'(s.e);
    rem = int'({s.g, s.r, s.s});
    up = (rem > 4) || (rem == 4 && (m % 2) == 1);
    inexact = (rem != 0);
    if (up) begin
      m = m + 1;
      if (m == 1024) begin
        m = 0;
        e = int'(s.ep);
      end
    end
    if (s.nan) begin
      z = 16'h7E00; f = 4'b0001;
    end else if (s.zero) begin
      z = {s.sign, 15'h0000}; f = 4'b0000;
    end else if (s.ovf || e == 31) begin
      z = {s.sign, 5'h1F, 10'h000}; f = {inexact, 3'b100};
    end else if (s.unf) begin
      z = {s.sign, 15'h0000}; f = {inexact, 3'b010};
    end else begin
      z = {s.sign, e[4:0], m[9:0]}; f = {inexact, 3'b000};
    end
    f = fx(f);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic apply(input stim_t s);
    cur = s;
    Sign = s.sign; RoundE = s.e; RoundEP = s.ep; RoundM = s.m; RoundMP = s.mp;
    G = s.g; R = s.r; S = s.s;
    ExpOvf = s.ovf; ExpUnf = s.unf; InNaN = s.nan; InZero = s.zero;
  endtask

  function automatic stim_t mk(input logic sg, input logic [4:0] e, input logic [4:0] ep,
                               input logic [9:0] m, input logic [9:0] mp,
                               input logic [2:0] grs, input logic [3:0] ounz);
    stim_t s;
    s.sign = sg; s.e = e; s.ep = ep; s.m = m; s.mp = mp;
    {s.g, s.r, s.s} = grs;
    {s.ovf, s.unf, s.nan, s.zero} = ounz;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sign = 1'($urandom);
    s.e    = 5'($urandom);
    s.ep   = s.e + 5'd1;
    s.m    = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
    s.mp   = s.m + 10'd1;
    s.g    = 1'($urandom);
    s.r    = 1'($urandom);
    s.s    = 1'($urandom);
    s.ovf  = ($urandom_range(0, 9) == 0);
    s.unf  = ($urandom_range(0, 9) == 0);
    s.nan  = ($urandom_range(0, 9) == 0);
    s.zero = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // One clock: observe the DUT just after the input change, score, advance
  task automatic step();
    logic [15:0] ez;
    logic [3:0]  ef;
    #1;
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    chk("out_valid", 32'(out_valid), 32'((q.size() > 0) && (q[0].t + 2 <= cyc)));
    if (hold_v) begin
      chk("hold_z", 32'(Z), 32'(hold_z));
      chk("hold_flags", 32'(Flags), 32'(hold_f));
    end
    hold_v = out_valid && !out_ready;
    hold_z = Z;
    hold_f = Flags;
    if (out_valid && out_ready && q.size() > 0) begin
      chk("result_z", 32'(Z), 32'(q[0].z));
      chk("result_flags", 32'(Flags), 32'(q[0].f));
      void'(q.pop_front());
    end
    acc_last = in_valid && in_ready;
    if (acc_last) begin
      if (dir_v) begin
        ez = dir_z; ef = dir_f;
      end else begin
        model(cur, ez, ef);
      end
      q.push_back('{z: ez, f: ef, t: cyc});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input stim_t s, input logic [15:0] z, input logic [3:0] f);
    apply(s);
    in_valid = 1'b1;
    dir_v = 1'b1; dir_z = z; dir_f = fx(f);
    step();
    chk("directed_accept", 32'(acc_last), 32'd1);
    in_valid = 1'b0;
    dir_v = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, before any clock edge
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_z", 32'(Z), 32'd0);
    chk("reset_flags", 32'(Flags), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;

    // Exact value, 2-cycle latency
    send(mk(1'b0, 5'h0F, 5'h10, 10'h200, 10'h201, 3'b000, 4'b0000), 16'h3E00, 4'b0000);
    drain();

    // Back-to-back rounding corners at full throughput
    send(mk(1'b0, 5'h0F, 5'h10, 10'h3FF, 10'h000, 3'b100, 4'b0000), 16'h4000, 4'b1000);
    send(mk(1'b0, 5'h0F, 5'h10, 10'h200, 10'h201, 3'b100, 4'b0000), 16'h3E00, 4'b1000);
    send(mk(1'b0, 5'h0F, 5'h10, 10'h201, 10'h202, 3'b100, 4'b0000), 16'h3E02, 4'b1000);
    send(mk(1'b1, 5'h0F, 5'h10, 10'h000, 10'h001, 3'b000, 4'b1000), 16'hFC00, 4'b0100);
    send(mk(1'b1, 5'h0F, 5'h10, 10'h000, 10'h001, 3'b000, 4'b1010), 16'h7E00, 4'b0001);
    send(mk(1'b0, 5'h1E, 5'h1F, 10'h3FF, 10'h000, 3'b110, 4'b0000), 16'h7C00, 4'b1100);
    send(mk(1'b1, 5'h01, 5'h02, 10'h155, 10'h156, 3'b001, 4'b0100), 16'h8000, 4'b1010);
    send(mk(1'b1, 5'h0F, 5'h10, 10'h155, 10'h156, 3'b111, 4'b1001), 16'h8000, 4'b0000);
    drain();

    // Output stall: three offered, two held, then in-order release
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(rand_stim()); step();
    apply(rand_stim()); step();
    apply(rand_stim()); step();
    chk("stall_blocks_third", 32'(acc_last), 32'd0);
    step();
    out_ready = 1'b1;
    step();
    chk("stall_third_taken", 32'(acc_last), 32'd1);
    drain();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(rand_stim()); step();
    apply(rand_stim()); step();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_z", 32'(Z), 32'd0);
    chk("async_rst_flags", 32'(Flags), 32'd0);
    q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if (acc_last || !in_valid) begin
        apply(rand_stim());
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
